// File: rtl/tft_rx_monitor_pkg.sv
// tft_rx_monitor_pkg: TFT timing constants shared with the driver and receiver FSM states
package tft_rx_monitor_pkg;
  localparam int H_ACTIVE = 480;
  localparam int V_ACTIVE = 272;
  localparam int H_TOTAL = 525;
  localparam int V_TOTAL = 288;
  localparam int VBLANK_THRESH = 525;
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    VBLANK   = 2'd1,
    LINE     = 2'd2,
    HBLANK   = 2'd3
  } state_t;
endpackage

// File: rtl/tft_rx_monitor_if.sv
// tft_rx_monitor_if: DE-mode TFT pixel bus (data enable plus 24-bit RGB)
interface tft_rx_monitor_if;
  logic       data_ena;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  modport master (output data_ena, red, green, blue);
  modport slave (input data_ena, red, green, blue);
endinterface

// File: rtl/tft_rx_monitor_checksum.sv
// tft_frame_checksum: mod-2^24 pixel accumulator committed to frame_checksum at frame end
module tft_frame_checksum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add_en,
  input  logic [23:0] add_val,
  input  logic        commit,
  output logic [23:0] frame_checksum
);
  logic [23:0] acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      frame_checksum <= '0;
    end else begin
      acc <= commit ? '0 : add_en ? acc + add_val : acc;
      frame_checksum <= commit ? acc : frame_checksum;
    end
endmodule

// File: rtl/tft_rx_monitor.sv
// tft_rx_monitor: DE-mode TFT sink rebuilding pixel coordinates, checking geometry and summing each frame
module tft_rx_monitor
  import tft_rx_monitor_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int V_ACT = V_ACTIVE,
  parameter int VB_TH = VBLANK_THRESH
) (
  input  logic             tft_clk,
  input  logic             rstb,
  tft_rx_monitor_if.slave  tft,
  input  logic             err_clear,
  output logic             locked,
  output logic             pix_valid,
  output logic [9:0]       pix_x,
  output logic [8:0]       pix_y,
  output logic [23:0]      pix_rgb,
  output logic             frame_done,
  output logic [23:0]      frame_checksum,
  output logic [15:0]      frame_count,
  output logic             line_len_err,
  output logic             frame_len_err
);
  state_t      state, state_nxt;
  logic [9:0]  low_cnt, x, cx, x_nxt;
  logic [8:0]  y, cy, y_nxt;
  logic [23:0] rgb;
  logic        vb_hit, take, frame_end, line_err, frame_err, lock_hit;
  assign rgb = {tft.red, tft.green, tft.blue};
  assign vb_hit = low_cnt == 10'(VB_TH);
  always_ff @(posedge tft_clk or negedge rstb)
    if (!rstb) state <= UNLOCKED;
    else state <= state_nxt;
  // the DE-rising sample is already pixel x=0, so cx/cy are the position of the current sample
  always_comb begin
    state_nxt = state;
    cx = state == LINE ? x : '0;
    cy = state == VBLANK ? '0 : y;
    x_nxt = x;
    y_nxt = y;
    frame_end = 1'b0;
    line_err = 1'b0;
    frame_err = 1'b0;
    lock_hit = 1'b0;
    if (tft.data_ena) begin
      x_nxt = &cx ? cx : cx + 10'd1;
      y_nxt = cy;
    end
    case (state)
      UNLOCKED: begin
        lock_hit = vb_hit;
        state_nxt = vb_hit ? VBLANK : UNLOCKED;
      end
      VBLANK: state_nxt = tft.data_ena ? LINE : VBLANK;
      LINE: if (!tft.data_ena) begin
        state_nxt = HBLANK;
        line_err = x != 10'(H_ACT);
        y_nxt = &y ? y : y + 9'd1;
      end
      HBLANK: begin
        state_nxt = tft.data_ena ? LINE : vb_hit ? VBLANK : HBLANK;
        frame_end = !tft.data_ena && vb_hit;
        frame_err = frame_end && y != 9'(V_ACT);
      end
      default: state_nxt = UNLOCKED;
    endcase
    take = tft.data_ena && state != UNLOCKED && cx < 10'(H_ACT) && cy < 9'(V_ACT);
  end
  always_ff @(posedge tft_clk or negedge rstb)
    if (!rstb) begin
      low_cnt <= '0;
      x <= '0;
      y <= '0;
      locked <= 1'b0;
      pix_valid <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_rgb <= '0;
      frame_done <= 1'b0;
      frame_count <= '0;
      line_len_err <= 1'b0;
      frame_len_err <= 1'b0;
    end else begin
      low_cnt <= tft.data_ena ? '0 : vb_hit ? low_cnt : low_cnt + 10'd1;
      x <= x_nxt;
      y <= y_nxt;
      locked <= locked | lock_hit;
      pix_valid <= take;
      pix_x <= take ? cx : pix_x;
      pix_y <= take ? cy : pix_y;
      pix_rgb <= take ? rgb : pix_rgb;
      frame_done <= frame_end;
      frame_count <= frame_count + {15'd0, frame_end};
      line_len_err <= line_err | (line_len_err & ~err_clear);
      frame_len_err <= frame_err | (frame_len_err & ~err_clear);
    end
  tft_frame_checksum u_checksum (
    .clk            (tft_clk),
    .rst_n          (rstb),
    .add_en         (take),
    .add_val        (rgb),
    .commit         (frame_end),
    .frame_checksum (frame_checksum)
  );
endmodule
